// File: rtl/mux_scan_sequencer.sv
// Self-timed four-channel scanner for the enabled 4:1 selector stage.
// Holds each channel for DWELL cycles, samples y per channel, then pulses done.
module mux_scan_sequencer #(
   parameter int DWELL = 4,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       y,
   output logic [1:0] sel,
   output logic       enable,
   output logic [3:0] sample,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sel;
   logic [3:0]       r_sample;
   logic             r_enable;
   logic             r_busy;
   logic             r_done;

   state_t           w_nextState;
   logic [CNT_W-1:0] w_nextCnt;
   logic [1:0]       w_nextSel;
   logic [3:0]       w_nextSample;
   logic             w_nextEnable;
   logic             w_nextBusy;
   logic             w_nextDone;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_sel    <= 2'd0;
         r_sample <= 4'd0;
         r_enable <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cnt    <= w_nextCnt;
         r_sel    <= w_nextSel;
         r_sample <= w_nextSample;
         r_enable <= w_nextEnable;
         r_busy   <= w_nextBusy;
         r_done   <= w_nextDone;
      end
   end

   // Outputs are computed here one cycle ahead so every port comes from a flop.
   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      w_nextSel    = r_sel;
      w_nextSample = r_sample;
      w_nextEnable = 1'b0;
      w_nextBusy   = 1'b0;
      w_nextDone   = 1'b0;

      if (abort) begin
         w_nextState = IDLE;
         w_nextCnt   = '0;
         w_nextSel   = 2'd0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               w_nextState = IDLE;
               if (start) begin
                  w_nextState  = SCAN;
                  w_nextCnt    = '0;
                  w_nextSel    = 2'd0;
                  w_nextSample = 4'd0;
                  w_nextEnable = 1'b1;
                  w_nextBusy   = 1'b1;
               end
            end
            SCAN: begin
               w_nextEnable = 1'b1;
               w_nextBusy   = 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_nextSample[r_sel] = y;
                  w_nextCnt           = '0;
                  if (r_sel == 2'd3) begin
                     w_nextState  = DONE;
                     w_nextSel    = 2'd0;
                     w_nextEnable = 1'b0;
                     w_nextBusy   = 1'b0;
                     w_nextDone   = 1'b1;
                  end else begin
                     w_nextSel = r_sel + 2'd1;
                  end
               end else begin
                  w_nextCnt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_nextState = IDLE;
               w_nextCnt   = '0;
               w_nextSel   = 2'd0;
            end
         endcase
      end
   end

   assign sel    = r_sel;
   assign enable = r_enable;
   assign sample = r_sample;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one instance at DWELL=4, one at DWELL=1,
// each fed by a modelled selector y = enable ? ch[sel] : 0.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;

   logic       start4 = 1'b0, abort4 = 1'b0, y4;
   logic [1:0] sel4;
   logic       en4, busy4, done4;
   logic [3:0] sample4;
   logic [3:0] ch4 = 4'b0000;

   logic       start1 = 1'b0, abort1 = 1'b0, y1;
   logic [1:0] sel1;
   logic       en1, busy1, done1;
   logic [3:0] sample1;
   logic [3:0] ch1 = 4'b0000;

   int errors = 0;
   int checks = 0;
   logic sawDone;

   always #5 clk = ~clk;

   assign y4 = en4 ? ch4[sel4] : 1'b0;
   assign y1 = en1 ? ch1[sel1] : 1'b0;

   mux_scan_sequencer #(.DWELL(4), .CNT_W(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .y(y4),
      .sel(sel4), .enable(en4), .sample(sample4), .busy(busy4), .done(done4)
   );

   mux_scan_sequencer #(.DWELL(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y(y1),
      .sel(sel1), .enable(en1), .sample(sample1), .busy(busy1), .done(done1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state, asserted between edges
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_sel", 32'(sel4), 0);
      checkOutput("rst_enable", 32'(en4), 0);
      checkOutput("rst_busy", 32'(busy4), 0);
      checkOutput("rst_done", 32'(done4), 0);
      checkOutput("rst_sample", 32'(sample4), 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Nominal scan, DWELL=4, ch=1010
      ch4 = 4'b1010;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) step();
         checkOutput($sformatf("nom_busy_%0d", k), 32'(busy4), 1);
         checkOutput($sformatf("nom_enable_%0d", k), 32'(en4), 1);
         checkOutput($sformatf("nom_sel_%0d", k), 32'(sel4), 32'(k / 4));
         checkOutput($sformatf("nom_done_%0d", k), 32'(done4), 0);
      end
      step();
      checkOutput("nom_done_16", 32'(done4), 1);
      checkOutput("nom_busy_16", 32'(busy4), 0);
      checkOutput("nom_enable_16", 32'(en4), 0);
      checkOutput("nom_sel_16", 32'(sel4), 0);
      checkOutput("nom_sample", 32'(sample4), 32'h0000000a);
      step();
      checkOutput("nom_done_17", 32'(done4), 0);
      checkOutput("nom_sample_hold", 32'(sample4), 32'h0000000a);

      // Abort during channel 2
      ch4 = 4'b1111;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      checkOutput("abt_start_sample", 32'(sample4), 0);
      for (int k = 1; k <= 9; k++) step();
      checkOutput("abt_sel_9", 32'(sel4), 2);
      checkOutput("abt_busy_9", 32'(busy4), 1);
      abort4 = 1'b1;
      step();
      abort4 = 1'b0;
      checkOutput("abt_enable", 32'(en4), 0);
      checkOutput("abt_busy", 32'(busy4), 0);
      checkOutput("abt_sel", 32'(sel4), 0);
      checkOutput("abt_sample", 32'(sample4), 32'h3);
      sawDone = done4;
      for (int k = 0; k < 20; k++) begin
         step();
         if (done4) sawDone = 1'b1;
      end
      checkOutput("abt_nodone", 32'(sawDone), 0);
      checkOutput("abt_sample_hold", 32'(sample4), 32'h3);

      // Ignored mid-scan start, then restart from the DONE cycle
      ch4 = 4'b0101;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 1; k <= 5; k++) step();
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      checkOutput("rs_mid_sel", 32'(sel4), 1);
      checkOutput("rs_mid_busy", 32'(busy4), 1);
      for (int k = 7; k <= 15; k++) step();
      checkOutput("rs_sel_15", 32'(sel4), 3);
      step();
      checkOutput("rs_done", 32'(done4), 1);
      checkOutput("rs_sample", 32'(sample4), 32'h5);
      ch4 = 4'b0011;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      checkOutput("rs2_busy", 32'(busy4), 1);
      checkOutput("rs2_done", 32'(done4), 0);
      checkOutput("rs2_sample_clr", 32'(sample4), 0);
      checkOutput("rs2_sel", 32'(sel4), 0);
      for (int k = 1; k <= 16; k++) step();
      checkOutput("rs2_done_16", 32'(done4), 1);
      checkOutput("rs2_sample", 32'(sample4), 32'h3);
      step();

      // Minimum dwell, DWELL=1, ch=0110
      ch1 = 4'b0110;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         checkOutput($sformatf("min_sel_%0d", k), 32'(sel1), 32'(k));
         checkOutput($sformatf("min_busy_%0d", k), 32'(busy1), 1);
         checkOutput($sformatf("min_done_%0d", k), 32'(done1), 0);
      end
      step();
      checkOutput("min_done_4", 32'(done1), 1);
      checkOutput("min_sample", 32'(sample1), 32'h6);
      step();
      checkOutput("min_done_5", 32'(done1), 0);

      // start and abort together in IDLE
      start4 = 1'b1;
      abort4 = 1'b1;
      step();
      start4 = 1'b0;
      abort4 = 1'b0;
      checkOutput("pri_busy", 32'(busy4), 0);
      checkOutput("pri_enable", 32'(en4), 0);
      checkOutput("pri_sample", 32'(sample4), 32'h3);
      step();
      checkOutput("pri_busy_after", 32'(busy4), 0);

      // Asynchronous reset in the middle of a scan
      ch4 = 4'b1111;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 1; k <= 6; k++) step();
      checkOutput("mrst_pre_sample", 32'(sample4), 32'h1);
      checkOutput("mrst_pre_busy", 32'(busy4), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mrst_sel", 32'(sel4), 0);
      checkOutput("mrst_enable", 32'(en4), 0);
      checkOutput("mrst_busy", 32'(busy4), 0);
      checkOutput("mrst_done", 32'(done4), 0);
      checkOutput("mrst_sample", 32'(sample4), 0);
      step();
      rst_n = 1'b1;
      step();
      checkOutput("mrst_idle_busy", 32'(busy4), 0);
      checkOutput("mrst_idle_enable", 32'(en4), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
